// File: rtl/test_logic_unit.sv
// test_logic_unit: registered two-input logic cell with per-input
// synchronizer and debounce filter feeding a parameter-selected Boolean op.
// Optional macro TEST_STICKY_EN: output latches high until reset.
module test_logic_unit #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned OP          = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   output logic y
);

   logic [SYNC_STAGES-1:0] sync_a;
   logic [SYNC_STAGES-1:0] sync_b;
   logic                   sa;
   logic                   sb;
   logic                   fa;
   logic                   fb;
   logic                   y_nxt;

   // Synchronizer chains: shift the raw inputs in at bit 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= (sync_a << 1) | SYNC_STAGES'(a);
         sync_b <= (sync_b << 1) | SYNC_STAGES'(b);
      end
   end

   assign sa = sync_a[SYNC_STAGES-1];
   assign sb = sync_b[SYNC_STAGES-1];

   if (DEBOUNCE == 0) begin : g_bypass
      assign fa = sa;
      assign fb = sb;
   end else begin : g_deb
      localparam int unsigned CNT_W = 8;
      logic [CNT_W-1:0] cnt_a;
      logic [CNT_W-1:0] cnt_b;
      logic             fa_q;
      logic             fb_q;

      // Debounce A: adopt a new value only after DEBOUNCE stable samples.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_a <= '0;
            fa_q  <= 1'b0;
         end else if (sa == fa_q) begin
            cnt_a <= '0;
         end else if (cnt_a == CNT_W'(DEBOUNCE - 1)) begin
            fa_q  <= sa;
            cnt_a <= '0;
         end else begin
            cnt_a <= cnt_a + CNT_W'(1);
         end
      end

      // Debounce B: same rule, independent counter.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_b <= '0;
            fb_q  <= 1'b0;
         end else if (sb == fb_q) begin
            cnt_b <= '0;
         end else if (cnt_b == CNT_W'(DEBOUNCE - 1)) begin
            fb_q  <= sb;
            cnt_b <= '0;
         end else begin
            cnt_b <= cnt_b + CNT_W'(1);
         end
      end

      assign fa = fa_q;
      assign fb = fb_q;
   end

   // Boolean function select; unknown codes fall back to AND.
   always_comb begin
      y_nxt = fa & fb;
      case (OP)
         1:       y_nxt = fa | fb;
         2:       y_nxt = fa ^ fb;
         3:       y_nxt = ~(fa & fb);
         4:       y_nxt = ~(fa | fb);
         5:       y_nxt = ~(fa ^ fb);
         default: y_nxt = fa & fb;
      endcase
   end

   // Output register (optionally sticky-high until reset).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y <= 1'b0;
      end else begin
`ifdef TEST_STICKY_EN
         y <= y | y_nxt;
`else
         y <= y_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_test_logic_unit.sv
// Bench for test_logic_unit: several parameterizations share the inputs and
// are compared each cycle against a sample-history reference model.
module tb_test_logic_unit;

   localparam int NI  = 9;
   localparam int S_M = 2;

   typedef logic lq_t[$];

   logic clk = 1'b0;
   logic rst;
   logic a;
   logic b;
   logic y_and;
   logic y_nand;
   logic [6:0] y_sw;
   logic [NI-1:0] yv;

   int tests = 0;
   int fails = 0;

   int   dm [NI] = '{4, 4, 0, 0, 0, 0, 0, 0, 0};
   int   om [NI] = '{0, 3, 0, 1, 2, 3, 4, 5, 7};
   logic fam[NI];
   logic fbm[NI];
   logic ym [NI];
   lq_t  ha, hb, sah_a, sah_b;
   logic [3:0] tt[7];

   always #5 clk = ~clk;

   test_logic_unit #(.SYNC_STAGES(2), .DEBOUNCE(4), .OP(0)) u_and (
      .clk(clk), .rst(rst), .a(a), .b(b), .y(y_and));
   test_logic_unit #(.SYNC_STAGES(2), .DEBOUNCE(4), .OP(3)) u_nand (
      .clk(clk), .rst(rst), .a(a), .b(b), .y(y_nand));

   for (genvar g = 0; g < 7; g++) begin : g_sw
      test_logic_unit #(.SYNC_STAGES(2), .DEBOUNCE(0),
                        .OP((g == 6) ? 7 : g)) u_sw (
         .clk(clk), .rst(rst), .a(a), .b(b), .y(y_sw[g]));
   end

   assign yv = {y_sw, y_nand, y_and};

   function automatic logic opm(input int code, input logic x, input logic z);
      case (code)
         1:       return x | z;
         2:       return x ^ z;
         3:       return ~(x & z);
         4:       return ~(x | z);
         5:       return ~(x ^ z);
         default: return x & z;
      endcase
   endfunction

   // True when the last d synchronized samples all differ from f.
   function automatic logic win(input lq_t q, input int d, input logic f);
      for (int i = 1; i <= d; i++)
         if (q[q.size() - i] !== ~f) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      ha = {}; hb = {}; sah_a = {}; sah_b = {};
      repeat (S_M - 1) begin ha.push_back(1'b0); hb.push_back(1'b0); end
      repeat (8) begin sah_a.push_back(1'b0); sah_b.push_back(1'b0); end
      for (int i = 0; i < NI; i++) begin
         fam[i] = 1'b0; fbm[i] = 1'b0; ym[i] = 1'b0;
      end
   endtask

   task automatic model_step(input logic xa, input logic xb);
      logic sa, sb, yn;
      ha.push_back(xa);
      hb.push_back(xb);
      sa = ha[ha.size() - S_M];
      sb = hb[hb.size() - S_M];
      for (int i = 0; i < NI; i++) begin
         yn = opm(om[i], fam[i], fbm[i]);
`ifdef TEST_STICKY_EN
         yn = yn | ym[i];
`endif
         ym[i] = yn;
         if (dm[i] == 0) begin
            fam[i] = sa;
            fbm[i] = sb;
         end else begin
            if (win(sah_a, dm[i], fam[i])) fam[i] = ~fam[i];
            if (win(sah_b, dm[i], fbm[i])) fbm[i] = ~fbm[i];
         end
      end
      sah_a.push_back(sa);
      sah_b.push_back(sb);
      if (ha.size() > 16) begin void'(ha.pop_front()); void'(hb.pop_front()); end
      if (sah_a.size() > 16) begin void'(sah_a.pop_front()); void'(sah_b.pop_front()); end
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      for (int i = 0; i < NI; i++)
         chk($sformatf("model_inst%0d", i), yv[i], ym[i]);
   endtask

   // One clock: capture inputs, step the model on the edge, check 1 ns later.
   task automatic tick();
      logic xa, xb, r;
      xa = a; xb = b; r = rst;
      @(posedge clk);
      #1;
      if (r) model_step(xa, xb);
      else   model_reset();
      chk_all();
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < NI; i++)
         chk($sformatf("async_rst_inst%0d", i), yv[i], 1'b0);
   endtask

   initial begin
      tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
      tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b1000;
      rst = 1'b0; a = 1'b0; b = 1'b0;
      model_reset();

      // Reset hold with toggling inputs.
      for (int i = 0; i < 20; i++) begin
         a = 1'($urandom); b = 1'($urandom);
         tick();
         chk("rst_hold_and", y_and, 1'b0);
      end

      // Release; NAND settles to 1 one edge later.
      a = 1'b0; b = 1'b0;
      rst = 1'b1;
      tick();
      chk("release_nand", y_nand, 1'b1);
      chk("release_and", y_and, 1'b0);

      // AND default path: a alone keeps y low, b rises after 7 edges.
      a = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("and_only_a", y_and, 1'b0);
      end
      b = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 6) chk("and_lat_pre", y_and, 1'b0);
         if (k == 7) chk("and_lat_rise", y_and, 1'b1);
      end

      // Glitch rejection on b.
      repeat (5) tick();
      b = 1'b0;
      repeat (3) tick();
      b = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("glitch3_hold", y_and, 1'b1);
      end
      b = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 5) b = 1'b1;
         tick();
`ifndef TEST_STICKY_EN
         if (k == 6) chk("glitch4_pre", y_and, 1'b1);
         if (k == 7) chk("glitch4_fall", y_and, 1'b0);
`endif
      end
      repeat (8) tick();

      // Function sweep on the DEBOUNCE=0 instances.
      for (int s = 0; s < 4; s++) begin
         a = (s >= 2);
         b = ((s % 2) == 1);
         for (int k = 1; k <= 5; k++) begin
            tick();
`ifndef TEST_STICKY_EN
            if (k == 3)
               for (int g = 0; g < 7; g++)
                  chk($sformatf("sweep_op%0d_ab%0d", (g == 6) ? 7 : g, s),
                      y_sw[g], tt[g][s]);
`endif
         end
      end

      // Random segments with varying hold lengths.
      for (int seg = 0; seg < 80; seg++) begin
         a = 1'($urandom); b = 1'($urandom);
         repeat ($urandom_range(1, 6)) tick();
      end

      // Async reset mid-operation, then full-latency recovery.
      a = 1'b1; b = 1'b1;
      repeat (10) tick();
      chk("pre_async_and", y_and, 1'b1);
      async_reset();
      repeat (2) tick();
      rst = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 6) chk("recover_pre", y_and, 1'b0);
         if (k == 7) chk("recover_rise", y_and, 1'b1);
      end

`ifdef TEST_STICKY_EN
      // Sticky: y holds after b drops, clears only on reset.
      b = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("sticky_hold", y_and, 1'b1);
      end
      async_reset();
      tick();
      rst = 1'b1;
      tick();
      chk("sticky_cleared", y_and, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/test_logic_unit.md
Name: test_logic_unit

Overview:
- Registered two-input logic cell with glitch filtering, used as a small self-check and demo block.
- Asynchronous single-bit inputs a and b pass through a synchronizer chain and then a per-input debounce filter.
- A parameter-selected Boolean function combines the two filtered inputs into a registered output y.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer chain; legal range 1..4.
- DEBOUNCE, 4, consecutive cycles a synchronized input must hold a new value before the filtered value takes it; 0 bypasses the filter; legal range 0..255.
- OP, 0, function code: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; any other code behaves as 0 (AND).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- a  input  1  operand A; may be asynchronous to clk.
- b  input  1  operand B; may be asynchronous to clk.
- y  output  1  registered result, OP(fa, fb).

Behaviour:
- Reset:
  - rst low immediately clears all synchronizer flops, filtered values fa/fb, debounce counters and y to 0, for every OP code.
  - Reset is released synchronously on the first rising clk edge with rst high.
- Synchronizer:
  - sa is a delayed by SYNC_STAGES rising edges; sb is b likewise.
- Debounce, per input, with counter width 8:
  - DEBOUNCE=0: fa equals sa; no additional register stage.
  - If sa == fa: counter cleared.
  - Else if counter == DEBOUNCE-1: fa <= sa and counter cleared.
  - Otherwise the counter increments.
  - Effect: a change must stay stable for DEBOUNCE consecutive sampled cycles.
  - A pulse shorter than DEBOUNCE sampled cycles never reaches fa; the counter restarts whenever sa returns to fa.
- Output:
  - y <= OP(fa, fb) every rising edge.
  - After reset release, y settles to OP(0,0) on the next edge; for example, NAND gives y=1 one cycle after release.
- Latency from an input change, sampled at edge 0, to y:
  - SYNC_STAGES + DEBOUNCE + 1 edges.
  - Defaults: 7 edges. With DEBOUNCE=0: SYNC_STAGES + 1 edges.
- Simultaneous changes:
  - a and b are filtered independently.
  - If both change together, y may show one intermediate value for one cycle only when their filters complete on different edges. With identical, clean stimulus they complete on the same edge and y switches once.
- No handshake. y is valid every cycle outside reset.

Optional Feature:
- Macro: TEST_STICKY_EN.
- Defined:
  - Adds a sticky latch in the output stage: once y is 1, it stays 1 until rst goes low, whatever OP(fa, fb) does afterwards.
  - The latch clears only on reset.
- Undefined:
  - y follows OP(fa, fb) every cycle as specified above.
  - No extra state is present.

Test Plan:
- Reset hold: rst=0, with a and b toggling arbitrarily for 20 cycles -> y=0 throughout, for all OP codes.
- AND default path: release rst, a=1, then b=1 ten cycles later -> y rises to 1 exactly 7 edges after b is sampled high; it stays 0 while only a=1.
- Glitch rejection: defaults, a=b=1 steady with y=1, then b pulsed to 0 for 3 cycles -> y stays 1; the same pulse held 4 cycles -> y falls to 0 seven edges after the pulse starts.
- Function sweep: DEBOUNCE=0, SYNC_STAGES=2, OP=0..5 with (a,b) stepped 00,01,10,11 and 5 cycles each -> y gives AND 0001, OR 0111, XOR 0110, NAND 1110, NOR 1000, XNOR 1001, each value 3 edges after the input step; OP=7 matches AND.
- Async reset mid-operation: y=1, rst driven low between clock edges -> y goes to 0 immediately, with no clk edge needed; after release, y recovers only after full latency.
- Sticky, TEST_STICKY_EN defined, OP=0: drive a=b=1 until y=1, then drop b to 0 -> y stays 1; pulse rst low -> y=0.
